// File: rtl/spi_mosi_arbiter.sv
// Two-requester round-robin arbiter that frames each granted {address, data}
// pair with spi_cs and shifts it out MSB first on spi_mosi_out.
module spi_mosi_arbiter #(
    parameter int unsigned CS_SETUP = 1,
    parameter int unsigned CS_IDLE  = 2
) (
    input  logic        spi_clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [7:0]  add0,
    input  logic [7:0]  data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [7:0]  add1,
    input  logic [7:0]  data1,
    output logic        ack1,
    output logic        spi_cs,
    output logic        spi_mosi_out,
    output logic        busy,
    output logic        done,
    output logic        grant_id,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ADDR,
        DATA,
        GAP
    } state_e;

    localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
    localparam logic [3:0] IDLE_LAST  = 4'(CS_IDLE - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] shift_q, shift_d;
    logic        prio_q, prio_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        grant_q, grant_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        win;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        prio_d      = prio_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        done_d      = 1'b0;
        cs_d        = cs_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        grant_d     = grant_q;
        frame_cnt_d = frame_cnt_q;
        win         = 1'b0;

        unique case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (req0 || req1) begin
                    // A lone request wins outright; a tie goes to the priority holder.
                    win     = (req0 && req1) ? prio_q : req1;
                    shift_d = win ? {add1, data1} : {add0, data0};
                    ack0_d  = ~win;
                    ack1_d  = win;
                    grant_d = win;
                    prio_d  = ~win;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    mosi_d  = shift_q[15];
                    shift_d = {shift_q[14:0], 1'b0};
                    bit_d   = 3'd7;
                    state_d = ADDR;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ADDR: begin
                mosi_d  = shift_q[15];
                shift_d = {shift_q[14:0], 1'b0};
                if (bit_q == 3'd0) begin
                    bit_d   = 3'd7;
                    state_d = DATA;
                end else begin
                    bit_d = bit_q - 3'd1;
                end
            end
            DATA: begin
                if (bit_q == 3'd0) begin
                    cs_d        = 1'b1;
                    mosi_d      = 1'b0;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    cnt_d       = '0;
                    state_d     = GAP;
                end else begin
                    mosi_d  = shift_q[15];
                    shift_d = {shift_q[14:0], 1'b0};
                    bit_d   = bit_q - 3'd1;
                end
            end
            GAP: begin
                if (cnt_q == IDLE_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge spi_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            prio_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            grant_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            prio_q      <= prio_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            grant_q     <= grant_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign spi_cs       = cs_q;
    assign spi_mosi_out = mosi_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign grant_id     = grant_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_spi_mosi_arbiter.sv
// Bench for spi_mosi_arbiter: a frame-timeline reference model checked every
// cycle, a table of granted frames, directed corner cases and random traffic.
module tb_spi_mosi_arbiter;

    localparam int CS_SETUP = 1;
    localparam int CS_IDLE  = 2;
    localparam int S        = CS_SETUP;
    localparam int L        = CS_SETUP + CS_IDLE + 17;

    logic        spi_clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [7:0]  add0, data0, add1, data1;
    logic        ack0, ack1, spi_cs, spi_mosi_out, busy, done, grant_id;
    logic [15:0] frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 0;

    spi_mosi_arbiter #(.CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE)) dut (
        .spi_clk(spi_clk), .reset(reset),
        .req0(req0), .add0(add0), .data0(data0), .ack0(ack0),
        .req1(req1), .add1(add1), .data1(data1), .ack1(ack1),
        .spi_cs(spi_cs), .spi_mosi_out(spi_mosi_out), .busy(busy),
        .done(done), .grant_id(grant_id), .frame_cnt(frame_cnt)
    );

    always #5 spi_clk = ~spi_clk;
    always @(posedge spi_clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a frame is a timeline t = 0 .. L-1 from the grant edge.
    bit          m_active = 0;
    int          m_t      = 0;
    bit          m_prio   = 0;
    bit          m_gid    = 0;
    bit          m_win;
    bit          m_ack0   = 0;
    bit          m_ack1   = 0;
    logic [15:0] m_word   = '0;
    logic [15:0] m_fc     = '0;

    always @(posedge spi_clk) begin
        m_ack0 = 0;
        m_ack1 = 0;
        if (reset) begin
            m_active = 0; m_t = 0; m_prio = 0; m_gid = 0; m_fc = '0;
        end else if (!m_active || m_t == L - 1) begin
            if (req0 || req1) begin
                m_win    = (req0 && req1) ? m_prio : req1;
                m_word   = m_win ? {add1, data1} : {add0, data0};
                m_ack0   = !m_win;
                m_ack1   = m_win;
                m_gid    = m_win;
                m_prio   = !m_win;
                m_active = 1;
                m_t      = 0;
            end else begin
                m_active = 0;
            end
        end else begin
            m_t++;
            if (m_t == S + 16) m_fc++;
        end
    end

    logic e_cs, e_mosi, e_done, e_busy;
    always @(negedge spi_clk) begin
        if (chk_en) begin
            e_cs   = !(m_active && m_t < S + 16);
            e_mosi = 1'b0;
            if (m_active && m_t >= S && m_t < S + 16) e_mosi = m_word[15 - (m_t - S)];
            e_done = m_active && (m_t == S + 16);
            e_busy = m_active && (m_t < L - 1);
            chk("spi_cs", spi_cs, e_cs);
            chk("spi_mosi_out", spi_mosi_out, e_mosi);
            chk("done", done, e_done);
            chk("busy", busy, e_busy);
            chk("ack0", ack0, m_ack0);
            chk("ack1", ack1, m_ack1);
            chk("grant_id", grant_id, m_gid);
            chk("frame_cnt", frame_cnt, m_fc);
        end
    end

    // Requests one frame, holds req for exactly the cycles up to ack, then
    // scrambles all inputs and checks the frame as seen on the pins.
    task automatic run_frame(input string nm, input logic r0, input logic r1,
                             input logic [7:0] a0, input logic [7:0] d0,
                             input logic [7:0] a1, input logic [7:0] d1,
                             input logic exp_gid, input logic [15:0] exp_word);
        logic        got0, got1;
        int          waited, cs_low, n_done;
        logic [15:0] word;
        req0 = r0; req1 = r1; add0 = a0; data0 = d0; add1 = a1; data1 = d1;
        got0 = 0; got1 = 0; waited = 0;
        while (!got0 && !got1 && waited < 3 * L) begin
            @(negedge spi_clk);
            waited++;
            got0 = ack0;
            got1 = ack1;
        end
        req0 = 0; req1 = 0;
        chk({nm, "_ack"}, {got1, got0}, exp_gid ? 32'd2 : 32'd1);
        if (!got0 && !got1) return;
        add0 = 8'hFF; data0 = 8'hFF; add1 = 8'hFF; data1 = 8'hFF;
        chk({nm, "_gid"}, grant_id, exp_gid);
        cs_low = (spi_cs == 1'b0) ? 1 : 0;
        n_done = 0;
        word   = '0;
        for (int p = 1; p <= S + 16; p++) begin
            @(negedge spi_clk);
            if (p >= S && p < S + 16) word = {word[14:0], spi_mosi_out};
            if (!spi_cs) cs_low++;
            if (done) n_done++;
        end
        chk({nm, "_word"}, word, exp_word);
        chk({nm, "_cs_low"}, cs_low, S + 16);
        chk({nm, "_done"}, n_done, 1);
    endtask

    task automatic wait_idle(input string nm);
        int w;
        w = 0;
        while (busy && w < 3 * L) begin
            @(negedge spi_clk);
            w++;
        end
        chk({nm, "_idle"}, busy, 0);
    endtask

    typedef struct {
        logic        r0, r1;
        logic [7:0]  a0, d0, a1, d1;
        logic        gid;
        logic [15:0] word;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          n_ack, last_cyc, n_done;
        logic [3:0]  exp_alt;
        logic        bad;

        vecs[0] = '{1'b1, 1'b0, 8'd45,  8'd1,  8'h00, 8'h00, 1'b0, 16'h2D01};
        vecs[1] = '{1'b1, 1'b1, 8'h47, 8'h61, 8'h23, 8'h0A, 1'b1, 16'h230A};
        vecs[2] = '{1'b1, 1'b1, 8'h47, 8'h61, 8'h23, 8'h0A, 1'b0, 16'h4761};
        vecs[3] = '{1'b1, 1'b1, 8'h47, 8'h61, 8'h23, 8'h0A, 1'b1, 16'h230A};
        vecs[4] = '{1'b1, 1'b1, 8'h47, 8'h61, 8'h23, 8'h0A, 1'b0, 16'h4761};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hA5, 8'h5A, 1'b1, 16'hA55A};
        vecs[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 16'hFF00};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h80, 8'h55, 8'h55, 1'b0, 16'h0080};
        vecs[8] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 16'h3344};

        reset = 1; req0 = 0; req1 = 0;
        add0 = '0; data0 = '0; add1 = '0; data1 = '0;
        repeat (3) @(negedge spi_clk);
        chk_en = 1;
        chk("rst_cs", spi_cs, 1);
        chk("rst_mosi", spi_mosi_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        reset = 0;

        // Both requests held from reset: grants alternate 0,1,0,1 every L cycles.
        req0 = 1; req1 = 1;
        add0 = 8'h47; data0 = 8'h61; add1 = 8'h23; data1 = 8'h0A;
        exp_alt  = 4'b1010;
        n_ack    = 0;
        last_cyc = 0;
        for (int k = 0; k < 5 * L && n_ack < 4; k++) begin
            @(negedge spi_clk);
            if (ack0 || ack1) begin
                chk("alt_gid", grant_id, exp_alt[n_ack]);
                if (n_ack > 0) chk("alt_spacing", cyc - last_cyc, L);
                last_cyc = cyc;
                n_ack++;
            end
        end
        chk("alt_count", n_ack, 4);
        req0 = 0; req1 = 0;

        for (int i = 0; i < 9; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].a0,
                      vecs[i].d0, vecs[i].a1, vecs[i].d1, vecs[i].gid, vecs[i].word);

        // Reset during DATA bit 3; a req0 present on the reset edge must not be acked.
        wait_idle("pre_rst");
        req1 = 1; add1 = 8'hC3; data1 = 8'h5E;
        n_ack = 0;
        for (int k = 0; k < 3 * L && n_ack == 0; k++) begin
            @(negedge spi_clk);
            if (ack1) n_ack = 1;
        end
        chk("rstmid_ack1", n_ack, 1);
        req1 = 0;
        repeat (S + 12) @(negedge spi_clk);
        reset = 1; req0 = 1;
        @(negedge spi_clk);
        reset = 0; req0 = 0;
        chk("rstmid_cs", spi_cs, 1);
        chk("rstmid_done", done, 0);
        chk("rstmid_frame_cnt", frame_cnt, 0);
        chk("rstmid_ack", {ack1, ack0}, 0);
        n_done = 0;
        for (int k = 0; k < L + 5; k++) begin
            @(negedge spi_clk);
            if (done) n_done++;
        end
        chk("rstmid_no_done", n_done, 0);
        run_frame("post_rst", 0, 1, 8'h00, 8'h00, 8'h9C, 8'h36, 1'b1, 16'h9C36);

        // Counter wrap from a preloaded 0xFFFF.
        wait_idle("wrap");
        #2;
        force dut.frame_cnt_q = 16'hFFFF;
        m_fc = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        @(negedge spi_clk);
        chk("wrap_preload", frame_cnt, 16'hFFFF);
        run_frame("wrap_frame", 1, 0, 8'h3C, 8'hC3, 8'h00, 8'h00, 1'b0, 16'h3CC3);
        chk("wrap_zero", frame_cnt, 0);

        // One-cycle req1 in GAP is never seen; one-cycle req1 in IDLE is.
        req1 = 1; add1 = 8'h12; data1 = 8'h34;
        @(negedge spi_clk);
        req1 = 0;
        bad = 0;
        for (int k = 0; k < 2 * L; k++) begin
            @(negedge spi_clk);
            if (ack1 || !spi_cs) bad = 1;
        end
        chk("gap_pulse_ignored", bad, 0);
        run_frame("idle_pulse", 0, 1, 8'h00, 8'h00, 8'h12, 8'h34, 1'b1, 16'h1234);

        // Random traffic against the reference model.
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 500; i++) begin
                @(negedge spi_clk);
                reset = ($urandom_range(0, 299) == 0);
                req0  = ($urandom_range(0, 5) < blk);
                req1  = ($urandom_range(0, 5) < (5 - blk));
                add0  = 8'($urandom); data0 = 8'($urandom);
                add1  = 8'($urandom); data1 = 8'($urandom);
            end
        end
        reset = 0; req0 = 0; req1 = 0;
        repeat (2 * L) @(negedge spi_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mosi_arbiter.md
Name: spi_mosi_arbiter

Overview:
Shares one SPI MOSI link between two requesters. Each requester presents an address byte and a data byte under a req/ack handshake. The block arbitrates round-robin and frames the transfer with spi_cs. It then serializes address then data MSB-first on spi_mosi_out, one bit per spi_clk cycle. It sits between register-access masters and the SPI pins, replacing the directly driven spi_mosi_in/add_byte stimulus path.

Parameters:
CS_SETUP, 1, cycles spi_cs is low before the first address bit (legal range 1..15)
CS_IDLE, 2, cycles spi_cs is held high after the last data bit before the next arbitration (legal range 1..15)

Ports:
spi_clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 transfer request, level
add0  input  8  requester 0 address byte
data0  input  8  requester 0 data byte
ack0  output  1  one-cycle pulse; add0/data0 latched
req1  input  1  requester 1 transfer request, level
add1  input  8  requester 1 address byte
data1  input  8  requester 1 data byte
ack1  output  1  one-cycle pulse; add1/data1 latched
spi_cs  output  1  active-low chip select
spi_mosi_out  output  1  serial data, MSB first
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last data bit
grant_id  output  1  requester owning the current or last frame
frame_cnt  output  16  completed frames, wraps 0xFFFF->0

Behaviour:
- All outputs are registered. Reset values: spi_cs=1, spi_mosi_out=0, ack0=ack1=0, busy=0, done=0, grant_id=0, frame_cnt=0. Reset also sets state=IDLE and gives priority to requester 0.
- States: IDLE, SETUP, ADDR, DATA, GAP. A 4-bit cycle counter and a 3-bit bit index are used.
- IDLE: spi_cs=1, mosi=0. Requests are sampled only in IDLE. At an edge where any reqN=1:
  - pick the winner;
  - latch its add/data into a 16-bit shift register {add,data};
  - pulse ackN=1 for exactly one cycle;
  - set grant_id=N, spi_cs=0, busy=1;
  - go to SETUP.
- Arbitration: a single request wins outright. If both requests are high, the priority holder wins. After a grant to N, priority passes to the other requester.
- SETUP: spi_cs=0, mosi=0 for CS_SETUP cycles, then ADDR.
- ADDR: 8 cycles driving add[7..0], MSB first. DATA: 8 cycles driving data[7..0], MSB first. No gap between ADDR and DATA.
- At the edge after data bit 0: spi_cs=1, mosi=0, done=1 (one cycle), frame_cnt+1 (modulo 2^16), go to GAP.
- GAP: spi_cs=1 for CS_IDLE cycles, then IDLE. busy drops on IDLE entry.
- Timing: spi_cs low for exactly CS_SETUP+16 cycles. Frame start to next frame start with continuous requests is CS_SETUP+CS_IDLE+17 cycles (20 at defaults).
- Input changes after ack do not affect the frame in flight. A req still high after GAP is treated as a new request.
- A req that drops before IDLE samples it is never acked. A req raised mid-frame waits until IDLE.
- Reset mid-frame:
  - spi_cs=1 on the next edge;
  - the frame is aborted with no done pulse;
  - frame_cnt=0;
  - no ack is issued on the reset cycle.

Test Plan:
- Single request: req0=1, add0=8'd45, data0=8'd1 → ack0 pulses 1 cycle. spi_cs low 17 cycles. mosi after setup = 0010_1101_0000_0001. done once, frame_cnt=1, grant_id=0.
- Simultaneous requests after reset: req0=req1=1, add0=0x47/data0=0x61, add1=0x23/data1=0x0A, both held → frames alternate 0,1,0,1 with grant_id matching. Frame starts 20 cycles apart. Serial bits match each latched pair.
- Data change after ack: change data0 from 0x01 to 0xFF one cycle after ack0 → serial data byte is still 0x01.
- Reset mid-frame: assert reset for 1 cycle during DATA bit 3 → spi_cs=1 next edge, no done, frame_cnt=0. The next req1 frame starts from IDLE and is bit-exact.
- Counter wrap: preload 65535 completed frames (force or run) → next done wraps frame_cnt to 0.
- Short request: pulse req1 for 1 cycle during GAP → no ack1 and no frame. Pulse req1 for 1 cycle in IDLE → ack1 and a full frame.
